// File: rtl/sram_1r1w_pipe.sv
// sram_1r1w_pipe: single-clock 1R1W synchronous SRAM behavioural model.
// Lane-masked writes, 1- or 2-cycle read pipeline with a valid strobe,
// optional same-cycle write forwarding with a collision flag, and an
// optional post-reset zero sweep of the whole array.
module sram_1r1w_pipe #(
   parameter int DATA_WIDTH   = 64,
   parameter int ADDR_WIDTH   = 10,
   parameter int WMASK_WIDTH  = 8,
   parameter int READ_LATENCY = 1,
   parameter int BYPASS       = 1,
   parameter int INIT_CLEAR   = 1
) (
   input  logic                   clk0,
   input  logic                   rstb0,
   input  logic                   csb0,
   input  logic [ADDR_WIDTH-1:0]  addr0,
   input  logic [DATA_WIDTH-1:0]  din0,
   input  logic [WMASK_WIDTH-1:0] wmask0,
   input  logic                   csb1,
   input  logic [ADDR_WIDTH-1:0]  addr1,
   output logic [DATA_WIDTH-1:0]  dout1,
   output logic                   dout1_valid,
   output logic                   collision,
   output logic                   init_done
);

   localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
   localparam int LW        = DATA_WIDTH / WMASK_WIDTH;

   if (DATA_WIDTH % WMASK_WIDTH != 0) begin : g_bad_mask_width
      $fatal(1, "sram_1r1w_pipe: DATA_WIDTH must be divisible by WMASK_WIDTH");
   end

   typedef enum logic {
      ST_INIT,
      ST_READY
   } state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   init_cnt_q, init_cnt_d;
   logic                    init_done_q, init_done_d;
   logic                    sweep_we;

   // Requests are only honoured once init_done is visible to the user, so
   // the cycle where the FSM has just reached READY is still an idle cycle.
   logic                    wr_req;
   logic                    rd_req;
   logic                    rd_hit;

   // Array write port, shared between the zero sweep and user writes.
   logic [ADDR_WIDTH-1:0]   mem_wa;
   logic [DATA_WIDTH-1:0]   mem_wd;
   logic [WMASK_WIDTH-1:0]  mem_lane_we;

   logic [DATA_WIDTH-1:0]   mem [RAM_DEPTH];
   logic [DATA_WIDTH-1:0]   mem_rd_q;

   // First read stage: valid/collision plus the forwarding lanes that
   // get merged over the registered array word.
   logic                    s1_valid_q, s1_valid_d;
   logic                    s1_coll_q, s1_coll_d;
   logic [WMASK_WIDTH-1:0]  s1_fwd_mask_q, s1_fwd_mask_d;
   logic [DATA_WIDTH-1:0]   s1_fwd_data_q, s1_fwd_data_d;
   logic [DATA_WIDTH-1:0]   s1_word;

   // Sweep FSM: next state, counter and the readiness flag for the user.
   always_comb begin
      state_d     = state_q;
      init_cnt_d  = init_cnt_q;
      sweep_we    = 1'b0;
      init_done_d = (state_q == ST_READY);
      case (state_q)
         ST_INIT: begin
            sweep_we   = 1'b1;
            init_cnt_d = init_cnt_q + ADDR_WIDTH'(1);
            if (&init_cnt_q) begin
               state_d = ST_READY;
            end
         end
         default: begin
         end
      endcase
   end

   // Sweep FSM registers; reset restarts the sweep from address 0.
   always_ff @(posedge clk0 or negedge rstb0) begin
      if (!rstb0) begin
         state_q     <= (INIT_CLEAR != 0) ? ST_INIT : ST_READY;
         init_cnt_q  <= '0;
         init_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         init_cnt_q  <= init_cnt_d;
         init_done_q <= init_done_d;
      end
   end

   assign wr_req    = init_done_q & ~csb0 & (|wmask0);
   assign rd_req    = init_done_q & ~csb1;
   assign rd_hit    = wr_req & rd_req & (addr0 == addr1);
   assign init_done = init_done_q;

   // Write-port mux: the sweep writes a full zero word, users write lanes.
   always_comb begin
      mem_wa      = addr0;
      mem_wd      = din0;
      mem_lane_we = '0;
      if (sweep_we) begin
         mem_wa      = init_cnt_q;
         mem_wd      = '0;
         mem_lane_we = {WMASK_WIDTH{1'b1}};
      end else if (wr_req) begin
         mem_lane_we = wmask0;
      end
   end

   // Storage array with lane writes and a registered read (read-old-data).
   always_ff @(posedge clk0) begin
      for (int i = 0; i < WMASK_WIDTH; i++) begin
         if (mem_lane_we[i]) begin
            mem[mem_wa][i*LW +: LW] <= mem_wd[i*LW +: LW];
         end
      end
      if (rd_req) begin
         mem_rd_q <= mem[addr1];
      end
   end

   // Capture read strobe, collision and forwarding lanes for this read.
   always_comb begin
      s1_valid_d    = rd_req;
      s1_coll_d     = rd_hit;
      s1_fwd_mask_d = s1_fwd_mask_q;
      s1_fwd_data_d = s1_fwd_data_q;
      if (rd_req) begin
         s1_fwd_mask_d = (rd_hit && (BYPASS != 0)) ? wmask0 : '0;
         s1_fwd_data_d = din0;
      end
   end

   // First read stage registers; reset drops any in-flight read.
   always_ff @(posedge clk0 or negedge rstb0) begin
      if (!rstb0) begin
         s1_valid_q    <= 1'b0;
         s1_coll_q     <= 1'b0;
         s1_fwd_mask_q <= '0;
         s1_fwd_data_q <= '0;
      end else begin
         s1_valid_q    <= s1_valid_d;
         s1_coll_q     <= s1_coll_d;
         s1_fwd_mask_q <= s1_fwd_mask_d;
         s1_fwd_data_q <= s1_fwd_data_d;
      end
   end

   // Per-lane merge of forwarded write data over the old array word.
   for (genvar gi = 0; gi < WMASK_WIDTH; gi++) begin : g_lane
      assign s1_word[gi*LW +: LW] = s1_fwd_mask_q[gi] ? s1_fwd_data_q[gi*LW +: LW]
                                                      : mem_rd_q[gi*LW +: LW];
   end

   if (READ_LATENCY == 1) begin : g_lat1
      // mem_rd_q has no reset (it is the RAM output register), so dout1 is
      // forced to zero until the first read after reset lands.
      logic rd_seen_q, rd_seen_d;

      // Remember whether any read has completed since reset.
      always_comb begin
         rd_seen_d = rd_seen_q | s1_valid_q;
         if (rd_req) begin
            rd_seen_d = 1'b1;
         end
      end

      // Read-seen flag register.
      always_ff @(posedge clk0 or negedge rstb0) begin
         if (!rstb0) begin
            rd_seen_q <= 1'b0;
         end else begin
            rd_seen_q <= rd_seen_d;
         end
      end

      assign dout1       = rd_seen_q ? s1_word : '0;
      assign dout1_valid = s1_valid_q;
      assign collision   = s1_coll_q;
   end else if (READ_LATENCY == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] s2_data_q, s2_data_d;
      logic                  s2_valid_q, s2_valid_d;
      logic                  s2_coll_q, s2_coll_d;

      // Second stage only loads data when a read completes, so it holds.
      always_comb begin
         s2_data_d  = s2_data_q;
         s2_valid_d = s1_valid_q;
         s2_coll_d  = s1_coll_q;
         if (s1_valid_q) begin
            s2_data_d = s1_word;
         end
      end

      // Second read stage registers.
      always_ff @(posedge clk0 or negedge rstb0) begin
         if (!rstb0) begin
            s2_data_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_coll_q  <= 1'b0;
         end else begin
            s2_data_q  <= s2_data_d;
            s2_valid_q <= s2_valid_d;
            s2_coll_q  <= s2_coll_d;
         end
      end

      assign dout1       = s2_data_q;
      assign dout1_valid = s2_valid_q;
      assign collision   = s2_coll_q;
   end else begin : g_bad_latency
      $fatal(1, "sram_1r1w_pipe: READ_LATENCY must be 1 or 2");
   end

endmodule
